// File: rtl/memory_access_if.sv
// EX/MEM input bundle, stall handshake and MEM/WB outputs of the memory-access stage.
// MEMORY_ACCESS_FAULT_EN adds the addressFault output.
interface memory_access_if;
  logic [1:0]  writeBackControlIn;
  logic [2:0]  memAccessControlIn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [4:0]  rdIn;
  logic        stall;
  logic [1:0]  writeBackControlOut;
  logic [31:0] memReadData;
  logic [31:0] aluResultOut;
  logic [4:0]  rdOut;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
`ifdef MEMORY_ACCESS_FAULT_EN
  logic        addressFault;
`endif

  modport slave (
    input  writeBackControlIn, memAccessControlIn, address, writeData, rdIn,
`ifdef MEMORY_ACCESS_FAULT_EN
    output addressFault,
`endif
    output stall, writeBackControlOut, memReadData, aluResultOut, rdOut,
    output memWbRegWrite, memWbRd, memWbData
  );

  modport master (
    output writeBackControlIn, memAccessControlIn, address, writeData, rdIn,
`ifdef MEMORY_ACCESS_FAULT_EN
    input  addressFault,
`endif
    input  stall, writeBackControlOut, memReadData, aluResultOut, rdOut,
    input  memWbRegWrite, memWbRd, memWbData
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: word RAM, configurable wait states with stall, MEM/WB register.
// Optional MEMORY_ACCESS_FAULT_EN flags and suppresses accesses beyond the RAM.
module memory_access #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            resetN,
  memory_access_if.slave bus
);
  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_COUNT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT       state;
  logic [3:0]  count;
  logic [1:0]  wbLatch;
  logic [2:0]  macLatch;
  logic [31:0] addrLatch;
  logic [31:0] dataLatch;
  logic [4:0]  rdLatch;

  logic [31:0] mem [DEPTH];

  logic [1:0]            opWb;
  logic [2:0]            opMac;
  logic [31:0]           opAddr;
  logic [31:0]           opData;
  logic [4:0]            opRd;
  logic                  isMem;
  logic                  isStore;
  logic                  isLoad;
  logic                  complete;
  logic                  addrFault;
  logic [ADDR_WIDTH-1:0] wordIndex;
  logic [1:0]            lane;
  logic [31:0]           ramWord;
  logic [31:0]           loadValue;
  logic [31:0]           storeWord;
  logic                  writeEnable;

  // While waiting, the latched bundle drives the access; the live inputs are ignored.
  always_comb begin
    opWb   = bus.writeBackControlIn;
    opMac  = bus.memAccessControlIn;
    opAddr = bus.address;
    opData = bus.writeData;
    opRd   = bus.rdIn;
    if (state == WAIT) begin
      opWb   = wbLatch;
      opMac  = macLatch;
      opAddr = addrLatch;
      opData = dataLatch;
      opRd   = rdLatch;
    end
  end

  assign isMem     = opMac[2] | opMac[1];
  assign isStore   = opMac[1];
  assign isLoad    = opMac[2] & ~opMac[1];
  assign wordIndex = opAddr[ADDR_WIDTH+1:2];
  assign lane      = opAddr[1:0];
  assign complete  = ((state == IDLE) && (!isMem || (WAIT_STATES == 0))) ||
                     ((state == WAIT) && (count == 4'd1));

`ifdef MEMORY_ACCESS_FAULT_EN
  assign addrFault = isMem && (opAddr[31:ADDR_WIDTH+2] != '0);
`else
  logic unusedHighAddr;
  assign unusedHighAddr = ^opAddr[31:ADDR_WIDTH+2];
  assign addrFault      = 1'b0;
`endif

  // Byte lanes are little-endian; a byte store merges into the existing word.
  always_comb begin
    ramWord   = mem[wordIndex];
    loadValue = ramWord;
    storeWord = opData;
    if (opMac[0]) begin
      loadValue = {24'd0, ramWord[{lane, 3'b000} +: 8]};
      storeWord = ramWord;
      storeWord[{lane, 3'b000} +: 8] = opData[7:0];
    end
  end

  assign writeEnable = complete && isStore && !addrFault;

  always_ff @(negedge clk) begin
    if (writeEnable) begin
      mem[wordIndex] <= storeWord;
    end
  end

  // Control FSM and MEM/WB register; bubbles are issued while an access is still waiting.
  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      state                   <= IDLE;
      count                   <= 4'd0;
      bus.stall               <= 1'b0;
      bus.writeBackControlOut <= 2'b00;
      bus.memReadData         <= 32'd0;
      bus.aluResultOut        <= 32'd0;
      bus.rdOut               <= 5'd0;
      wbLatch                 <= 2'b00;
      macLatch                <= 3'b000;
      addrLatch               <= 32'd0;
      dataLatch               <= 32'd0;
      rdLatch                 <= 5'd0;
`ifdef MEMORY_ACCESS_FAULT_EN
      bus.addressFault        <= 1'b0;
`endif
    end else if (complete) begin
      state                   <= IDLE;
      count                   <= 4'd0;
      bus.stall               <= 1'b0;
      bus.writeBackControlOut <= addrFault ? 2'b00 : opWb;
      bus.memReadData         <= (isLoad && !addrFault) ? loadValue : 32'd0;
      bus.aluResultOut        <= opAddr;
      bus.rdOut               <= opRd;
`ifdef MEMORY_ACCESS_FAULT_EN
      bus.addressFault        <= addrFault;
`endif
    end else begin
      bus.writeBackControlOut <= 2'b00;
      bus.memReadData         <= 32'd0;
      bus.aluResultOut        <= 32'd0;
      bus.rdOut               <= 5'd0;
`ifdef MEMORY_ACCESS_FAULT_EN
      bus.addressFault        <= 1'b0;
`endif
      if (state == IDLE) begin
        state     <= WAIT;
        count     <= WAIT_COUNT;
        bus.stall <= 1'b1;
        wbLatch   <= bus.writeBackControlIn;
        macLatch  <= bus.memAccessControlIn;
        addrLatch <= bus.address;
        dataLatch <= bus.writeData;
        rdLatch   <= bus.rdIn;
      end else begin
        count <= count - 4'd1;
      end
    end
  end

  assign bus.memWbRegWrite = bus.writeBackControlOut[1];
  assign bus.memWbRd       = bus.rdOut;
  assign bus.memWbData     = bus.writeBackControlOut[0] ? bus.memReadData : bus.aluResultOut;
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: one DUT with two wait states, one with none.
// Expected MEM/WB traffic comes from an operation-level model of the stage.
module tb_memory_access;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk    = 1'b0;
  logic resetN = 1'b1;
  int   testCount = 0;
  int   failCount = 0;

  typedef struct {
    bit          bubble;
    bit          fault;
    logic        stall;
    logic [1:0]  wbc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } expRec;

  expRec       expA[$];
  expRec       expZ[$];
  logic [31:0] ramModel [int];

  memory_access_if ifA();
  memory_access_if ifZ();

  memory_access #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dutA (.clk(clk), .resetN(resetN), .bus(ifA));
  memory_access #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dutZ (.clk(clk), .resetN(resetN), .bus(ifZ));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Operation-level model: each op yields its stall bubbles followed by one result cycle.
  task automatic modelOp(input int which, input logic [1:0] wbc, input logic [2:0] mac,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                         output int edges);
    int unsigned a;
    int unsigned lane;
    int          key;
    bit          isMem, isStore, isLoad, fault;
    logic [31:0] w;
    int          ws;
    expRec       r;
    a       = addr;
    lane    = a % 4;
    key     = which * 65536 + int'((a / 4) % DEPTH);
    isMem   = mac[2] || mac[1];
    isStore = mac[1];
    isLoad  = mac[2] && !mac[1];
    fault   = 1'b0;
`ifdef MEMORY_ACCESS_FAULT_EN
    fault   = isMem && ((a / (4 * DEPTH)) != 0);
`endif
    w = ramModel.exists(key) ? ramModel[key] : 32'd0;
    r = '{bubble: 1'b0, fault: fault, stall: 1'b0, wbc: fault ? 2'b00 : wbc,
          rd: rd, alu: addr, rdata: 32'd0};
    if (isLoad && !fault)
      r.rdata = mac[0] ? ((w >> (8 * lane)) & 32'hFF) : w;
    if (isStore && !fault) begin
      if (mac[0]) w = (w & ~(32'hFF << (8 * lane))) | ((data & 32'hFF) << (8 * lane));
      else        w = data;
      ramModel[key] = w;
    end
    ws    = (which == 0) ? 2 : 0;
    edges = isMem ? ws + 1 : 1;
    for (int i = 0; i < edges - 1; i++) begin
      expRec b;
      b = '{bubble: 1'b1, fault: 1'b0, stall: 1'b1, wbc: 2'b00, rd: 5'd0, alu: 32'd0, rdata: 32'd0};
      if (which == 0) expA.push_back(b); else expZ.push_back(b);
    end
    if (which == 0) expA.push_back(r); else expZ.push_back(r);
  endtask

  // Called at a rising edge; presents one op and holds it until the stage completes it.
  task automatic applyStimulus(input int which, input logic [1:0] wbc, input logic [2:0] mac,
                               input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    int edges;
    #1;
    if (which == 0) begin
      ifA.writeBackControlIn = wbc; ifA.memAccessControlIn = mac;
      ifA.address = addr; ifA.writeData = data; ifA.rdIn = rd;
    end else begin
      ifZ.writeBackControlIn = wbc; ifZ.memAccessControlIn = mac;
      ifZ.address = addr; ifZ.writeData = data; ifZ.rdIn = rd;
    end
    modelOp(which, wbc, mac, addr, data, rd, edges);
    repeat (edges) @(posedge clk);
  endtask

  task automatic compareRec(input string tag, input expRec r, input logic stall, input logic [1:0] wbc,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                            input logic regWrite, input logic [4:0] wbRd, input logic [31:0] wbData,
                            input logic fault);
    checkOutput({tag, ".stall"}, 32'(stall), 32'(r.stall));
    checkOutput({tag, ".wbc"}, 32'(wbc), 32'(r.wbc));
    checkOutput({tag, ".memWbRegWrite"}, 32'(regWrite), 32'(r.wbc[1]));
    if (!r.fault) begin
      checkOutput({tag, ".rdOut"}, 32'(rd), 32'(r.rd));
      checkOutput({tag, ".memWbRd"}, 32'(wbRd), 32'(r.rd));
    end
    if (!r.bubble) begin
      checkOutput({tag, ".aluResultOut"}, alu, r.alu);
      checkOutput({tag, ".memReadData"}, rdata, r.rdata);
      checkOutput({tag, ".memWbData"}, wbData, r.wbc[0] ? r.rdata : r.alu);
    end
`ifdef MEMORY_ACCESS_FAULT_EN
    checkOutput({tag, ".addressFault"}, 32'(fault), 32'(r.fault));
`else
    if (fault) checkOutput({tag, ".addressFault"}, 32'(fault), 32'd0);
`endif
  endtask

  // Compare process: one expected record per falling edge, sampled at the following rising edge.
  initial begin
    expRec r;
    logic  faultA, faultZ;
    forever begin
      @(posedge clk);
`ifdef MEMORY_ACCESS_FAULT_EN
      faultA = ifA.addressFault;
      faultZ = ifZ.addressFault;
`else
      faultA = 1'b0;
      faultZ = 1'b0;
`endif
      if (expA.size() > 0) begin
        r = expA.pop_front();
        compareRec("A", r, ifA.stall, ifA.writeBackControlOut, ifA.rdOut, ifA.aluResultOut,
                   ifA.memReadData, ifA.memWbRegWrite, ifA.memWbRd, ifA.memWbData, faultA);
      end
      if (expZ.size() > 0) begin
        r = expZ.pop_front();
        compareRec("Z", r, ifZ.stall, ifZ.writeBackControlOut, ifZ.rdOut, ifZ.aluResultOut,
                   ifZ.memReadData, ifZ.memWbRegWrite, ifZ.memWbRd, ifZ.memWbData, faultZ);
      end
    end
  end

  initial begin
    ifA.writeBackControlIn = 2'b00; ifA.memAccessControlIn = 3'b000;
    ifA.address = 32'd0; ifA.writeData = 32'd0; ifA.rdIn = 5'd0;
    ifZ.writeBackControlIn = 2'b00; ifZ.memAccessControlIn = 3'b000;
    ifZ.address = 32'd0; ifZ.writeData = 32'd0; ifZ.rdIn = 5'd0;

    #1 resetN = 1'b0;
    #1;
    checkOutput("resetStall", 32'(ifA.stall), 32'd0);
    checkOutput("resetWbc", 32'(ifA.writeBackControlOut), 32'd0);
    checkOutput("resetRd", 32'(ifA.rdOut), 32'd0);
    checkOutput("resetAlu", ifA.aluResultOut, 32'd0);
    checkOutput("resetReadData", ifA.memReadData, 32'd0);
    @(posedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);

    applyStimulus(0, 2'b00, 3'b010, 32'h10, 32'h11111111, 5'd0);

    // Store that is aborted by reset one edge after acceptance.
    #1;
    ifA.memAccessControlIn = 3'b010; ifA.address = 32'h10; ifA.writeData = 32'hDEADBEEF;
    @(posedge clk);
    checkOutput("abortStallHigh", 32'(ifA.stall), 32'd1);
    #1 resetN = 1'b0;
    #1;
    checkOutput("abortStall", 32'(ifA.stall), 32'd0);
    checkOutput("abortWbc", 32'(ifA.writeBackControlOut), 32'd0);
    checkOutput("abortWbData", ifA.memWbData, 32'd0);
    ifA.memAccessControlIn = 3'b000; ifA.address = 32'd0; ifA.writeData = 32'd0;
    @(posedge clk);
    #2 resetN = 1'b1;
    @(posedge clk);
    applyStimulus(0, 2'b11, 3'b100, 32'h10, 32'd0, 5'd4);
    checkOutput("abortLoad", ifA.memWbData, 32'h11111111);

    // Word round trip.
    applyStimulus(0, 2'b00, 3'b010, 32'h20, 32'h12345678, 5'd0);
    applyStimulus(0, 2'b11, 3'b100, 32'h20, 32'd0, 5'd7);
    checkOutput("rtRd", 32'(ifA.memWbRd), 32'd7);
    checkOutput("rtData", ifA.memWbData, 32'h12345678);
    checkOutput("rtRegWrite", 32'(ifA.memWbRegWrite), 32'd1);

    // Byte lanes.
    applyStimulus(0, 2'b00, 3'b010, 32'h40, 32'hAABBCCDD, 5'd0);
    applyStimulus(0, 2'b00, 3'b011, 32'h42, 32'h00000011, 5'd0);
    applyStimulus(0, 2'b11, 3'b100, 32'h40, 32'd0, 5'd5);
    checkOutput("laneWord", ifA.memWbData, 32'hAA11CCDD);
    applyStimulus(0, 2'b11, 3'b101, 32'h43, 32'd0, 5'd6);
    checkOutput("laneByte", ifA.memWbData, 32'h000000AA);

    // Load followed by an ALU pass-through op.
    applyStimulus(0, 2'b11, 3'b100, 32'h20, 32'd0, 5'd8);
    applyStimulus(0, 2'b10, 3'b000, 32'h5, 32'd0, 5'd3);
    checkOutput("aluData", ifA.memWbData, 32'h5);
    checkOutput("aluRd", 32'(ifA.memWbRd), 32'd3);

    // memRead and memWrite together act as a store.
    applyStimulus(0, 2'b11, 3'b110, 32'h24, 32'h55, 5'd2);
    checkOutput("rwReadData", ifA.memReadData, 32'd0);
    applyStimulus(0, 2'b11, 3'b100, 32'h24, 32'd0, 5'd2);
    checkOutput("rwLoad", ifA.memWbData, 32'h55);
    applyStimulus(0, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);

    // Zero wait states, back-to-back, and out-of-range addressing.
    applyStimulus(1, 2'b00, 3'b010, 32'h8, 32'hCAFEF00D, 5'd0);
    applyStimulus(1, 2'b11, 3'b100, 32'h8, 32'd0, 5'd9);
    checkOutput("zeroWsLoad", ifZ.memWbData, 32'hCAFEF00D);
    applyStimulus(1, 2'b00, 3'b010, 32'h0, 32'h0A0A0A0A, 5'd0);
    applyStimulus(1, 2'b01, 3'b010, 32'h400, 32'hB0B0B0B0, 5'd0);
`ifdef MEMORY_ACCESS_FAULT_EN
    checkOutput("faultFlag", 32'(ifZ.addressFault), 32'd1);
`endif
    applyStimulus(1, 2'b11, 3'b100, 32'h0, 32'd0, 5'd1);
`ifdef MEMORY_ACCESS_FAULT_EN
    checkOutput("faultRam", ifZ.memWbData, 32'h0A0A0A0A);
`else
    checkOutput("aliasRam", ifZ.memWbData, 32'hB0B0B0B0);
`endif
    applyStimulus(1, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0);

    @(posedge clk);
    #1;
    checkOutput("drainA", 32'(expA.size()), 32'd0);
    checkOutput("drainZ", 32'(expZ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
